pattern_tx: RTL and testbench

- Serial pattern transmitter. It is the sending end of the serial pattern-detector interface.
- It latches a WIDTH-bit pattern on a start handshake and shifts it out MSB-first on a 1-bit line, one bit per clock.
- It can repeat the pattern a programmed number of times, with an optional idle gap between copies.
- Its out port drives the in port of a pattern detector directly, for loopback benches and stimulus generation.

---
 rtl/pattern_pkg.sv | 17 +
 rtl/pattern_tx.sv | 145 ++++++++++++++
 tb/tb_pattern_tx.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pattern_pkg.sv
// rtl/pattern_pkg.sv - shared definitions for the serial pattern transmitter and detector
package pattern_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_t;

  localparam int DEF_WIDTH = 5;

  // Width of a counter that indexes the bits of a w-bit pattern.
  function automatic int cnt_bits(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/pattern_tx.sv
// rtl/pattern_tx.sv - serial pattern transmitter, MSB-first, with repeat count and idle gap
module pattern_tx
  import pattern_pkg::*;
#(
  parameter int   WIDTH      = DEF_WIDTH,
  parameter int   CNT_W      = 4,
  parameter int   GAP_W      = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeats,
  input  logic [GAP_W-1:0] gap,
  input  logic             start,
  output logic             ready,
  output logic             out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = cnt_bits(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  tx_state_t        state, state_n;
  logic [WIDTH-1:0] pat_lat, pat_lat_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic [CNT_W-1:0] copies, copies_n;
  logic [GAP_W-1:0] gap_lat, gap_lat_n;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
  logic             out_n, bit_valid_n, ready_n, busy_n, done_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pat_lat   <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      copies    <= '0;
      gap_lat   <= '0;
      gap_cnt   <= '0;
      out       <= IDLE_LEVEL;
      bit_valid <= 1'b0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      pat_lat   <= pat_lat_n;
      shreg     <= shreg_n;
      bit_cnt   <= bit_cnt_n;
      copies    <= copies_n;
      gap_lat   <= gap_lat_n;
      gap_cnt   <= gap_cnt_n;
      out       <= out_n;
      bit_valid <= bit_valid_n;
      ready     <= ready_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  // Outputs are computed one cycle ahead so they can be registered; shreg
  // holds the bits still to be sent after the one currently on out.
  always_comb begin
    state_n     = state;
    pat_lat_n   = pat_lat;
    shreg_n     = shreg;
    bit_cnt_n   = bit_cnt;
    copies_n    = copies;
    gap_lat_n   = gap_lat;
    gap_cnt_n   = gap_cnt;
    out_n       = IDLE_LEVEL;
    bit_valid_n = 1'b0;
    ready_n     = 1'b0;
    busy_n      = 1'b0;
    done_n      = 1'b0;

    case (state)
      IDLE: begin
        ready_n = 1'b1;
        if (start && ready) begin
          state_n     = SEND;
          pat_lat_n   = pattern;
          shreg_n     = pattern << 1;
          bit_cnt_n   = '0;
          copies_n    = (repeats == '0) ? CNT_W'(1) : repeats;
          gap_lat_n   = gap;
          gap_cnt_n   = '0;
          out_n       = pattern[WIDTH-1];
          bit_valid_n = 1'b1;
          ready_n     = 1'b0;
          busy_n      = 1'b1;
        end
      end

      SEND: begin
        busy_n = 1'b1;
        if (bit_cnt != LAST_BIT) begin
          out_n       = shreg[WIDTH-1];
          bit_valid_n = 1'b1;
          shreg_n     = shreg << 1;
          bit_cnt_n   = bit_cnt + BW'(1);
        end else begin
          copies_n  = copies - CNT_W'(1);
          bit_cnt_n = '0;
          if (copies == CNT_W'(1)) begin
            state_n = IDLE;
            ready_n = 1'b1;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else if (gap_lat == '0) begin
            out_n       = pat_lat[WIDTH-1];
            bit_valid_n = 1'b1;
            shreg_n     = pat_lat << 1;
          end else begin
            state_n   = GAP;
            gap_cnt_n = GAP_W'(1);
          end
        end
      end

      GAP: begin
        busy_n = 1'b1;
        if (gap_cnt == gap_lat) begin
          state_n     = SEND;
          gap_cnt_n   = '0;
          out_n       = pat_lat[WIDTH-1];
          bit_valid_n = 1'b1;
          shreg_n     = pat_lat << 1;
        end else begin
          gap_cnt_n = gap_cnt + GAP_W'(1);
        end
      end

      default: begin
        state_n = IDLE;
        ready_n = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_pattern_tx.sv
// tb/tb_pattern_tx.sv - scoreboard bench for pattern_tx with directed transfers
module tb_pattern_tx;

  logic       clk;
  logic       rst_n;
  logic [4:0] pattern;
  logic [3:0] repeats;
  logic [3:0] gap;
  logic       start;
  logic       ready, out, bit_valid, busy, done;

  int tests;
  int fails;
  int busy_cnt;
  logic [1:0] exp_q[$];

  pattern_tx dut (
    .clk(clk), .rst_n(rst_n), .pattern(pattern), .repeats(repeats), .gap(gap),
    .start(start), .ready(ready), .out(out), .bit_valid(bit_valid), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {bit_valid,out} for every busy cycle of a transfer.
  task automatic push_exp(input logic [4:0] p, input int copies, input int g);
    for (int c = 0; c < copies; c++) begin
      for (int i = 4; i >= 0; i--) exp_q.push_back({1'b1, p[i]});
      if (c < copies - 1)
        for (int k = 0; k < g; k++) exp_q.push_back(2'b00);
    end
  endtask

  // Monitor: pops the scoreboard on every busy cycle, checks idle line otherwise.
  always @(negedge clk) begin
    logic [1:0] e;
    if (rst_n) begin
      if (busy) begin
        busy_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_underrun: busy cycle with empty scoreboard at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("sb_bit", {30'd0, bit_valid, out}, {30'd0, e});
        end
      end else begin
        chk("idle_line", {30'd0, bit_valid, out}, 32'd0);
      end
    end
  end

  // Caller must be just after a negedge; start is accepted at the next posedge.
  task automatic kick(input logic [4:0] p, input logic [3:0] r, input logic [3:0] g, input int copies);
    pattern  = p;
    repeats  = r;
    gap      = g;
    start    = 1'b1;
    busy_cnt = 0;
    push_exp(p, copies, int'(g));
    @(posedge clk);
    #1;
    start   = 1'b0;
    pattern = ~p;
    repeats = 4'd7;
    gap     = 4'd9;
  endtask

  // Counts negedges after acceptance until done; leaves the bench at the done negedge.
  task automatic wait_done(input string name, input int total, input int k0);
    int k;
    k = k0;
    while (k < 300) begin
      @(negedge clk);
      k++;
      if (done) break;
    end
    chk({name, "_done_lat"}, k, total + 1);
    chk({name, "_busy_cnt"}, busy_cnt, total);
    chk({name, "_ready_at_done"}, {31'd0, ready}, 32'd1);
  endtask

  task automatic check_done_single(input string name);
    @(negedge clk);
    chk({name, "_done_single"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    busy_cnt = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    pattern  = '0;
    repeats  = '0;
    gap      = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_out", {31'd0, out}, 32'd0);
    chk("rst_bv", {31'd0, bit_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single copy 11001.
    kick(5'b11001, 4'd1, 4'd0, 1);
    wait_done("single", 5, 0);
    check_done_single("single");

    // Three copies with a 2-cycle gap: 5*3 + 2*2 = 19 busy cycles.
    kick(5'b10110, 4'd3, 4'd2, 3);
    wait_done("gap2", 19, 0);
    check_done_single("gap2");

    // Two copies back-to-back.
    kick(5'b11001, 4'd2, 4'd0, 2);
    wait_done("b2b", 10, 0);
    check_done_single("b2b");

    // repeats=0 sends exactly one copy.
    kick(5'b10101, 4'd0, 4'd3, 1);
    wait_done("rep0", 5, 0);
    check_done_single("rep0");

    // Start mid-transfer is ignored; start during done cycle is accepted.
    kick(5'b11001, 4'd1, 4'd0, 1);
    repeat (3) @(negedge clk);
    pattern = 5'b00110;
    repeats = 4'd2;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ignore", 5, 3);
    kick(5'b01101, 4'd1, 4'd1, 1);
    @(negedge clk);
    chk("restart_busy", {31'd0, busy}, 32'd1);
    wait_done("restart", 5, 1);
    check_done_single("restart");

    // Maximum repeat count: 15 copies, no wrap.
    kick(5'b10010, 4'd15, 4'd0, 15);
    wait_done("max", 75, 0);
    check_done_single("max");

    // Reset at bit 3 aborts asynchronously with no done pulse.
    kick(5'b11001, 4'd2, 4'd1, 2);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out", {31'd0, out}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_ready", {31'd0, ready}, 32'd1);
    chk("arst_bv", {31'd0, bit_valid}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("arst_no_done", {30'd0, done, busy}, 32'd0);
    end
    kick(5'b10110, 4'd1, 4'd0, 1);
    wait_done("post_rst", 5, 0);
    check_done_single("post_rst");

    repeat (3) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
